// File: rtl/hrm_smp_buf_25b.sv
// Sample FIFO behind the 25-bit sin/cos harmonic generator; optional drop counter under HRM_SMP_BUF_OVF_CNT_EN.
// Latency: a sample captured on a tick edge is visible on o_data/o_valid right after that edge (show-ahead).
// Backpressure: i_ready=0 holds the head stable; ticks into a full buffer without a pop are dropped and flagged.
module hrm_smp_buf_25b #(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic [1:0][24:0] i_val,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [1:0][24:0] o_data,
    output logic [ADDR_W:0]  o_cnt,
    output logic             o_full,
    output logic             o_empty,
    input  logic             i_clr_ovf,
    output logic             o_ovf
`ifdef HRM_SMP_BUF_OVF_CNT_EN
    ,
    output logic [15:0]      o_ovf_cnt
`endif
);

    typedef logic [1:0][24:0] smp_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy register.
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] FULL_XOR = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    smp_t            mem_q [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic ovf_evt;

    // Status and handshake decode, all from the registered pointers.
    always_comb begin
        full    = (wr_ptr_q ^ rd_ptr_q) == FULL_XOR;
        empty   = (wr_ptr_q == rd_ptr_q);
        pop     = !empty && i_ready;
        // A pop on the same edge frees a slot, so a full buffer still accepts.
        push    = i_tick && (!full || pop);
        ovf_evt = i_tick && full && !pop;
    end

    // Next-state for pointers and the sticky overflow flag; a new drop beats a clear.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage; contents need no reset since empty pointers mask them.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_val;
        end
    end

    assign o_data  = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign o_valid = !empty;
    assign o_empty = empty;
    assign o_full  = full;
    assign o_cnt   = wr_ptr_q - rd_ptr_q;
    assign o_ovf   = ovf_q;

`ifdef HRM_SMP_BUF_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating drop counter; a drop coinciding with a clear restarts the count at 1.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_evt) begin
            if (i_clr_ovf) begin
                ovf_cnt_d = 16'd1;
            end else if (ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
        end else if (i_clr_ovf) begin
            ovf_cnt_d = 16'd0;
        end
    end

    // Drop counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_cnt_q <= 16'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_hrm_smp_buf_25b.sv
// Bench for hrm_smp_buf_25b: directed scenarios followed by randomized tick/ready traffic.
// A queue-based reference model predicts accepted samples, occupancy and overflow state;
// a separate monitor compares the DUT against it every cycle.
module tb_hrm_smp_buf_25b;

    localparam int DEPTH = 16;

    typedef logic [1:0][24:0] smp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_tick;
    smp_t        i_val;
    logic        o_valid;
    logic        i_ready;
    smp_t        o_data;
    logic [4:0]  o_cnt;
    logic        o_full;
    logic        o_empty;
    logic        i_clr_ovf;
    logic        o_ovf;
`ifdef HRM_SMP_BUF_OVF_CNT_EN
    logic [15:0] o_ovf_cnt;
`endif

    hrm_smp_buf_25b #(.DEPTH(DEPTH)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_tick    (i_tick),
        .i_val     (i_val),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_cnt     (o_cnt),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .i_clr_ovf (i_clr_ovf),
        .o_ovf     (o_ovf)
`ifdef HRM_SMP_BUF_OVF_CNT_EN
        ,
        .o_ovf_cnt (o_ovf_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: exp_q holds every accepted, not yet consumed sample in order.
    smp_t exp_q[$];
    int   m_cnt  = 0;
    bit   m_ovf  = 1'b0;
    int   m_ocnt = 0;
    // Snapshot of the model describing the DUT state after the most recent edge.
    int   chk_cnt  = 0;
    bit   chk_ovf  = 1'b0;
    int   chk_ocnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic smp_t mk(input int a0, input int a1);
        smp_t r;
        r[0] = 25'(a0);
        r[1] = 25'(a1);
        return r;
    endfunction

    function automatic smp_t rnd_smp();
        return mk(int'($urandom), int'($urandom));
    endfunction

    // One clock cycle of stimulus; the model is advanced to the state after the coming edge.
    task automatic cyc(input bit tick, input smp_t v, input bit rdy, input bit clr);
        bit take;
        bit give;
        bit drop;
        @(negedge clk);
        #1;
        chk_cnt   = m_cnt;
        chk_ovf   = m_ovf;
        chk_ocnt  = m_ocnt;
        i_tick    = tick;
        i_val     = v;
        i_ready   = rdy;
        i_clr_ovf = clr;
        give = (m_cnt > 0) && rdy;
        take = tick && ((m_cnt < DEPTH) || give);
        drop = tick && !take;
        if (take) exp_q.push_back(v);
        m_cnt = m_cnt + int'(take) - int'(give);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (drop && clr) m_ocnt = 1;
        else if (drop) m_ocnt = (m_ocnt < 65535) ? m_ocnt + 1 : 65535;
        else if (clr) m_ocnt = 0;
    endtask

    // Reset pulse between edges; outputs must clear before any clock edge.
    task automatic async_rst();
        cyc(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cnt", 64'(o_cnt), 64'd0);
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_ovf", 64'(o_ovf), 64'd0);
        check("arst_empty", 64'(o_empty), 64'd1);
        rst = 1'b0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_ocnt = 0;
        exp_q.delete();
    endtask

    // Monitor: compares status every cycle and the head sample whenever o_valid is high.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("cnt", 64'(o_cnt), 64'(chk_cnt));
                check("valid", 64'(o_valid), 64'(chk_cnt != 0));
                check("empty", 64'(o_empty), 64'(chk_cnt == 0));
                check("full", 64'(o_full), 64'(chk_cnt == DEPTH));
                check("ovf", 64'(o_ovf), 64'(chk_ovf));
`ifdef HRM_SMP_BUF_OVF_CNT_EN
                check("ovf_cnt", 64'(o_ovf_cnt), 64'(chk_ocnt));
`endif
                if (o_valid) begin
                    check("head_exists", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        check("data", 64'(o_data), 64'(exp_q[0]));
                        if (i_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int pt;
        int pr;
        rst       = 1'b1;
        i_tick    = 1'b0;
        i_val     = '0;
        i_ready   = 1'b0;
        i_clr_ovf = 1'b0;
        #3;
        check("rst_cnt", 64'(o_cnt), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_empty", 64'(o_empty), 64'd1);
        check("rst_full", 64'(o_full), 64'd0);
        check("rst_ovf", 64'(o_ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Five samples stored, then reset mid-stream.
        for (int i = 0; i < 5; i++) cyc(1'b1, mk(i, 500 + i), 1'b0, 1'b0);
        async_rst();

        // Single sample held under backpressure, then consumed.
        cyc(1'b1, mk(32'h1FFFFFF, 32'h0ABCDE), 1'b0, 1'b0);
        repeat (4) cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Fill with a ramp, overflow once, clear, then tick+pop while full, drain.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, mk(i, 1000 + i), 1'b0, 1'b0);
        cyc(1'b1, mk(DEPTH, 1000 + DEPTH), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, mk(77, 777), 1'b1, 1'b0);
        repeat (DEPTH + 1) cyc(1'b0, '0, 1'b1, 1'b0);

        // Streaming through the pointer wrap.
        for (int i = 0; i < 40; i++) cyc(1'b1, rnd_smp(), 1'b1, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        // Repeated drops, clear coinciding with a drop, then reset while full and flagged.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, rnd_smp(), 1'b0, 1'b0);
        repeat (3) cyc(1'b1, rnd_smp(), 1'b0, 1'b0);
        cyc(1'b1, rnd_smp(), 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        async_rst();

        // Randomized traffic with varying tick and ready densities.
        for (int b = 0; b < 10; b++) begin
            pt = int'($urandom_range(20, 95));
            pr = int'($urandom_range(5, 90));
            for (int c = 0; c < 200; c++) begin
                cyc($urandom_range(0, 99) < pt, rnd_smp(),
                    $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 3);
            end
        end

        // Drain and confirm every accepted sample came out.
        repeat (DEPTH + 2) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
